// File: rtl/sfu_ctrl.sv
// Control sequencer for the SFU bank and its partial-sum SRAM: per row it pops the
// output FIFO, reads psum, pulses the SFU, then writes back, over several accumulation passes.
module sfu_ctrl #(
   parameter int addr_bw = 4,
   parameter int len     = 16,
   parameter int pass_bw = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [pass_bw-1:0] num_pass,
   input  logic [addr_bw-1:0] base_addr,
   input  logic               ofifo_valid,
   output logic               ofifo_rd,
   output logic               pmem_cen,
   output logic               pmem_wen,
   output logic [addr_bw-1:0] pmem_addr,
   output logic               sfu_valid,
   output logic               acc_clr,
   output logic               relu_en,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {IDLE, RD, EX, WR, DONE} state_t;

   localparam logic [addr_bw-1:0] row_last = addr_bw'(len - 1);

   state_t             state;
   logic [addr_bw-1:0] base;
   logic [addr_bw-1:0] row;
   logic [pass_bw-1:0] pass;
   logic [pass_bw-1:0] last;

   // Outputs are registered, so every RD strobe is decided from ofifo_valid sampled on the
   // edge that enters or re-enters RD; ofifo_rd high in RD means the pop was issued this cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         base      <= '0;
         row       <= '0;
         pass      <= '0;
         last      <= '0;
         ofifo_rd  <= 1'b0;
         pmem_cen  <= 1'b1;
         pmem_wen  <= 1'b1;
         pmem_addr <= '0;
         sfu_valid <= 1'b0;
         acc_clr   <= 1'b0;
         relu_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         ofifo_rd  <= 1'b0;
         pmem_cen  <= 1'b1;
         pmem_wen  <= 1'b1;
         sfu_valid <= 1'b0;
         acc_clr   <= 1'b0;
         relu_en   <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  base      <= base_addr;
                  last      <= (num_pass == '0) ? '0 : num_pass - pass_bw'(1);
                  row       <= '0;
                  pass      <= '0;
                  busy      <= 1'b1;
                  state     <= RD;
                  pmem_addr <= base_addr;
                  ofifo_rd  <= ofifo_valid;
                  pmem_cen  <= ~ofifo_valid;
               end
            end
            RD: begin
               if (ofifo_rd) begin
                  state     <= EX;
                  sfu_valid <= 1'b1;
                  acc_clr   <= (pass == '0);
                  relu_en   <= (pass == last);
               end else begin
                  ofifo_rd  <= ofifo_valid;
                  pmem_cen  <= ~ofifo_valid;
               end
            end
            EX: begin
               state    <= WR;
               pmem_cen <= 1'b0;
               pmem_wen <= 1'b0;
               relu_en  <= relu_en;
            end
            WR: begin
               if (row != row_last) begin
                  row       <= row + addr_bw'(1);
                  pmem_addr <= base + row + addr_bw'(1);
                  state     <= RD;
                  ofifo_rd  <= ofifo_valid;
                  pmem_cen  <= ~ofifo_valid;
               end else begin
                  row       <= '0;
                  pmem_addr <= base;
                  if (pass == last) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     pass     <= pass + pass_bw'(1);
                     state    <= RD;
                     ofifo_rd <= ofifo_valid;
                     pmem_cen <= ~ofifo_valid;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sfu_ctrl.sv
// Scoreboard bench for sfu_ctrl: stimulus queues expected strobe events with cycle offsets,
// a monitor pops and compares them and models the psum SRAM accumulate path.
module tb_sfu_ctrl;
   localparam int LEN  = 4;
   localparam int NONE = 1000;

   logic       clk = 1'b0, reset = 1'b0, start = 1'b0, ofifo_valid = 1'b0;
   logic [3:0] num_pass = '0, base_addr = '0;
   logic       ofifo_rd, pmem_cen, pmem_wen, sfu_valid, acc_clr, relu_en, busy, done;
   logic [3:0] pmem_addr;

   sfu_ctrl #(.addr_bw(4), .len(LEN), .pass_bw(4)) dut (
      .clk(clk), .reset(reset), .start(start), .num_pass(num_pass), .base_addr(base_addr),
      .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd), .pmem_cen(pmem_cen), .pmem_wen(pmem_wen),
      .pmem_addr(pmem_addr), .sfu_valid(sfu_valid), .acc_clr(acc_clr), .relu_en(relu_en),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [4:0] code;   // {ofifo_rd, ~cen, ~wen, sfu_valid, done}
      logic [3:0] addr;
      logic       clr;
      logic       relu;
      logic       bsy;
      int         off;
   } ev_t;

   ev_t exp_q[$];
   int  fifo_q[$];
   int  mem[16];
   int  k = 0;
   int  passed = 0, checks = 0;
   int  cur_row = 0, acc = 0;
   logic [3:0] rd_addr = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic push_ev(input logic [4:0] code, input int addr, input logic clr,
                          input logic relu, input int off);
      ev_t e;
      e.code = code; e.addr = 4'(addr); e.clr = clr; e.relu = relu; e.bsy = 1'b1; e.off = off;
      exp_q.push_back(e);
   endtask

   task automatic plan_tile(input int base, input int p_eff, input int wait_row, input int wait_n);
      int i, off;
      for (int p = 0; p < p_eff; p++)
         for (int r = 0; r < LEN; r++) begin
            i   = p * LEN + r;
            off = 1 + 3 * i + ((i >= wait_row) ? wait_n : 0);
            push_ev(5'b11000, (base + r) % 16, 1'b0, 1'b0, off);
            push_ev(5'b00010, 0, p == 0, p == p_eff - 1, off + 1);
            push_ev(5'b01100, (base + r) % 16, 1'b0, p == p_eff - 1, off + 2);
         end
      push_ev(5'b00001, 0, 1'b0, 1'b0, 3 * LEN * p_eff + 1 + ((wait_row < NONE) ? wait_n : 0));
   endtask

   task automatic start_tile(input int base, input int np);
      @(negedge clk);
      base_addr = 4'(base);
      num_pass  = 4'(np);
      start     = 1'b1;
      k         = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check({name, "_done_timeout"}, n, 0);
      @(negedge clk);
      check({name, "_idle_busy"}, int'(busy), 0);
      check({name, "_events_left"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_outs(input string name);
      check(name, int'({ofifo_rd, pmem_cen, pmem_wen, pmem_addr, sfu_valid, acc_clr, relu_en,
                        busy, done}), 12'h600);
   endtask

   task automatic mon_step();
      ev_t a, e;
      logic [4:0] code;
      code = {ofifo_rd, ~pmem_cen, ~pmem_wen, sfu_valid, done};
      if (code == 5'b0 && !acc_clr && !relu_en) return;
      a.code = code; a.addr = (!pmem_cen) ? pmem_addr : 4'h0;
      a.clr = acc_clr; a.relu = relu_en; a.bsy = busy; a.off = cyc - k;
      checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL unexpected_event: code=%b addr=%0d off=%0d, none expected", a.code, a.addr, a.off);
      end else begin
         e = exp_q.pop_front();
         if (a.code == e.code && a.addr == e.addr && a.clr == e.clr && a.relu == e.relu &&
             a.bsy == e.bsy && a.off == e.off)
            passed++;
         else
            $display("FAIL event: got code=%b addr=%0d clr=%b relu=%b busy=%b off=%0d expected code=%b addr=%0d clr=%b relu=%b busy=%b off=%0d",
                     a.code, a.addr, a.clr, a.relu, a.bsy, a.off, e.code, e.addr, e.clr, e.relu, e.bsy, e.off);
      end
      if (ofifo_rd) begin
         cur_row = (fifo_q.size() > 0) ? fifo_q.pop_front() : 0;
         rd_addr = pmem_addr;
      end
      if (sfu_valid) acc = (acc_clr ? 0 : mem[rd_addr]) + cur_row;
      if (!pmem_cen && !pmem_wen) mem[pmem_addr] = (relu_en && acc < 0) ? 0 : acc;
   endtask

   initial forever begin
      @(negedge clk);
      if (reset) mon_step();
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 50;
      repeat (3) @(negedge clk);
      check_reset_outs("reset_values");
      reset = 1'b1;
      ofifo_valid = 1'b1;

      // single pass, base 0: stale 50s must be cleared by acc_clr, ReLU applied
      fifo_q = '{-1, 7, 0, -9};
      plan_tile(0, 1, NONE, 0);
      start_tile(0, 1);
      wait_done("single");
      check("single_mem0", mem[0], 0);
      check("single_mem1", mem[1], 7);
      check("single_mem3", mem[3], 0);

      // three passes, base 2
      fifo_q = '{5, -3, 2, -10, 1, -4, -6, 3, -2, 1, 7, 4};
      plan_tile(2, 3, NONE, 0);
      start_tile(2, 3);
      wait_done("pass3");
      check("pass3_mem2", mem[2], 4);
      check("pass3_mem3", mem[3], 0);
      check("pass3_mem4", mem[4], 3);
      check("pass3_mem5", mem[5], 0);

      // ofifo_valid low for 5 sampling edges before row 1
      fifo_q = '{0, 0, 0, 0};
      plan_tile(5, 1, 1, 5);
      start_tile(5, 1);
      @(negedge clk);
      @(negedge clk);
      ofifo_valid = 1'b0;
      repeat (5) @(negedge clk);
      ofifo_valid = 1'b1;
      wait_done("stall");

      // address wrap
      fifo_q = '{0, 0, 0, 0};
      plan_tile(14, 1, NONE, 0);
      start_tile(14, 1);
      wait_done("wrap");

      // num_pass 0 acts as 1; start and inputs changed while busy are ignored
      fifo_q = '{0, 0, 0, 0};
      plan_tile(7, 1, NONE, 0);
      start_tile(7, 0);
      repeat (3) @(negedge clk);
      start = 1'b1; num_pass = 4'd3; base_addr = 4'd0;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done("np0");

      // reset during EX of pass 1, then a fresh tile
      fifo_q = '{0, 0, 0, 0, 0, 0, 0, 0};
      plan_tile(3, 2, NONE, 0);
      start_tile(3, 2);
      repeat (13) @(negedge clk);
      #2;
      reset = 1'b0;
      exp_q.delete();
      fifo_q.delete();
      #1;
      check_reset_outs("midtile_reset");
      @(negedge clk);
      check_reset_outs("midtile_reset_held");
      reset = 1'b1;
      fifo_q = '{1, 2, 3, 4, 10, -20, 30, -40};
      plan_tile(3, 2, NONE, 0);
      start_tile(3, 2);
      wait_done("after_reset");
      check("after_reset_mem3", mem[3], 11);
      check("after_reset_mem4", mem[4], 0);
      check("after_reset_mem5", mem[5], 33);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/sfu_ctrl.md
# sfu_ctrl

Sequencer for the column-wide SFU bank and its partial-sum SRAM. For each output tile it pops rows from the output FIFO, reads the matching partial-sum row from psum memory, pulses the SFU bank's `valid`, and writes the accumulated row back to the same address. It repeats this over a programmable number of accumulation passes, zeroes the memory operand on the first pass, and requests ReLU on the last pass. The block is control-only: FIFO data, SRAM data and the SFU bank data buses are wired at the core level.

## Interface
Parameters:
- `addr_bw`, default 4: psum SRAM address width.
- `len`, default 16: rows per tile, 1..2^addr_bw.
- `pass_bw`, default 4: width of the pass-count input.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `num_pass`  in  pass_bw  accumulation passes for the tile; 0 is treated as 1; latched on `start`.
- `base_addr`  in  addr_bw  first psum row address; latched on `start`.
- `ofifo_valid`  in  1  output FIFO has at least one full row.
- `ofifo_rd`  out  1  pop one FIFO row; the row is presented next cycle.
- `pmem_cen`  out  1  SRAM chip enable, active-low.
- `pmem_wen`  out  1  SRAM write enable, active-low.
- `pmem_addr`  out  addr_bw  SRAM address.
- `sfu_valid`  out  1  drives the SFU bank `valid`.
- `acc_clr`  out  1  core muxes the bank's `psum_mem` to zero while this is high.
- `relu_en`  out  1  core applies ReLU to the SFU bank `psum_out` before SRAM write data.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the tile completes.

## Operation
- States and transitions: IDLE, RD, EX, WR, DONE.
- IDLE: on `start`=1, latch `base_addr` and `max(num_pass,1)`; clear `row` and `pass`; go to RD.
- RD: if `ofifo_valid`=0, hold with no strobes. If `ofifo_valid`=1, assert `ofifo_rd`=1, `pmem_cen`=0, `pmem_wen`=1 and `pmem_addr`=`base+row`, then go to EX.
- EX: FIFO row and SRAM Q are valid this cycle. Assert `sfu_valid`=1, `acc_clr`=(pass==0) and `relu_en`=(pass==last). Go to WR.
- WR: the SFU output is registered and valid this cycle. Assert `pmem_cen`=0 and `pmem_wen`=0 with the same address as RD, and hold `relu_en` as in EX. Then:
  - if `row`<len-1: `row`++ and go to RD;
  - otherwise: `row`=0. If `pass`==last go to DONE, else `pass`++ and go to RD.
- DONE: `done`=1; go to IDLE.
- Address arithmetic is `base+row` mod 2^addr_bw, so it wraps silently.
- Read and write never share a cycle, so a single-port SRAM is sufficient.
- `start` is ignored outside IDLE. `start` and `num_pass` changes mid-tile have no effect.
- A single-pass tile has `acc_clr` and `relu_en` both high in every EX cycle.

## Timing
- All outputs are Moore decodes of registered state and counters; there are no combinational input-to-output paths.
- Reset values: state IDLE, `row`=0, `pass`=0. Outputs `ofifo_rd`=0, `pmem_cen`=1, `pmem_wen`=1, `pmem_addr`=0, `sfu_valid`=0, `acc_clr`=0, `relu_en`=0, `busy`=0, `done`=0.
- Reset mid-tile returns to IDLE immediately; any partial SRAM write state is discarded.
- Each row takes 3 cycles (RD, EX, WR) when `ofifo_valid` is held high. Each cycle RD waits adds 1 cycle.
- With `start` seen at edge k and `ofifo_valid` held high: first `ofifo_rd` in cycle k+1, final write in cycle k+3·len·P, `done` in cycle k+3·len·P+1, IDLE at the following edge. P is the effective pass count.
- Per row: `sfu_valid` occurs exactly 1 cycle after `ofifo_rd`, and the SRAM write exactly 2 cycles after `ofifo_rd`.

## Test plan
- Single pass, len=4, base=0, `ofifo_valid` tied high → reads at addresses 0,1,2,3 every 3 cycles; `acc_clr` and `relu_en` high in all 4 EX cycles; `done` at k+13.
- `num_pass`=3, len=4, base=2 → 12 read/write pairs cycling addresses 2..5; `acc_clr` only in pass 0, `relu_en` only in pass 2; `done` at k+37. A scoreboard checks that the SRAM holds ReLU of the sum of the 3 FIFO rows.
- `ofifo_valid` low for 5 cycles before row 1 → RD holds with no strobes; total latency grows by exactly 5; no duplicate pops.
- base=14, len=4, addr_bw=4 → addresses 14,15,0,1 (wrap).
- `num_pass`=0 → behaves identically to 1; `start` pulsed while busy → ignored, no change in counts.
- `reset` asserted during EX of pass 1 → next edge is IDLE with all outputs at reset values; a fresh `start` runs a full tile correctly.
